iq_read_sched: RTL

Read-side thread scheduler for the per-thread extra-instruction queue. Each cycle it picks which hardware thread (0/1) the queue reads and how many entries are consumed: none, one or two. Thread selection is round-robin with a fixed read quantum, a one-cycle bubble on every thread switch, and a per-thread post-exception flush window. It sits between the queue's occupancy counters and its read port, and drives the queue's read_thread / read_cnt inputs.

---
 rtl/iq_read_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/iq_read_sched.sv
// rtl/iq_read_sched.sv - read-side thread scheduler for the per-thread extra-instruction queue
//
// Purpose: each cycle picks the thread (0/1) the queue reads and how many
// entries it consumes (0/1/2). Round-robin with a fixed read quantum, a
// one-cycle bubble on every thread switch and a per-thread flush window
// after an exception.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-low reset
//   stall          downstream stall; reads are consumed only when low
//   except         exception flush pulse
//   except_thread  thread being flushed
//   thread_en[1:0] per-thread enable
//   cnt0, cnt1     per-thread queue occupancy
//   issue_max      downstream read limit (0,1,2; 3 behaves as 2)
//   read_thread    selected thread (registered)
//   read_cnt       one-hot read count 001=0, 010=1, 100=2 (combinational)
//   switching      high during the switch bubble (registered)
//   flushing[1:0]  per-thread flush window active (registered)
//   full[1:0]      occupancy at or above FULL_LVL (combinational)

module iq_read_sched #(
  parameter int QUANTUM   = 8,
  parameter int FLUSH_CYC = 3,
  parameter int FULL_LVL  = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       except,
  input  logic       except_thread,
  input  logic [1:0] thread_en,
  input  logic [4:0] cnt0,
  input  logic [4:0] cnt1,
  input  logic [1:0] issue_max,
  output logic       read_thread,
  output logic [2:0] read_cnt,
  output logic       switching,
  output logic [1:0] flushing,
  output logic [1:0] full
);

  typedef enum logic {RUN = 1'b0, SWITCH = 1'b1} state_t;

  localparam logic [3:0] QMAX = 4'(QUANTUM - 1);

  state_t     state;
  logic [3:0] qcnt;
  logic [2:0] fl [2];

  logic [1:0] elig;
  logic       cur;
  logic       oth;
  logic [4:0] cnt_cur;
  logic       rd;
  logic       sw_go;

  assign cur     = read_thread;
  assign oth     = ~read_thread;
  assign cnt_cur = cur ? cnt1 : cnt0;

  assign elig[0] = thread_en[0] & (fl[0] == 3'd0) & (cnt0 != 5'd0);
  assign elig[1] = thread_en[1] & (fl[1] == 3'd0) & (cnt1 != 5'd0);

  always_comb begin
    read_cnt = 3'b001;
    if ((state == RUN) && elig[cur]) begin
      if ((cnt_cur >= 5'd2) && (issue_max >= 2'd2))
        read_cnt = 3'b100;
      else if (issue_max >= 2'd1)
        read_cnt = 3'b010;
    end
  end

  // read_cnt is one-hot, so bit 0 alone marks "no read".
  assign rd = (state == RUN) & elig[cur] & ~read_cnt[0] & ~stall;

  // Uses the current fl values, so an exception arriving this cycle only
  // affects eligibility from the next cycle on.
  assign sw_go = (state == RUN) & elig[oth] & (~elig[cur] | (rd & (qcnt >= QMAX)));

  assign switching = (state == SWITCH);
  assign flushing  = {fl[1] != 3'd0, fl[0] != 3'd0};
  assign full      = {cnt1 >= 5'(FULL_LVL), cnt0 >= 5'(FULL_LVL)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      read_thread <= 1'b0;
      qcnt        <= 4'd0;
      fl[0]       <= 3'd0;
      fl[1]       <= 3'd0;
    end else begin
      if (!stall) begin
        if (state == SWITCH) begin
          state <= RUN;
        end else if (sw_go) begin
          read_thread <= oth;
          qcnt        <= 4'd0;
          state       <= SWITCH;
        end else if (rd) begin
          // Saturate so a lone eligible thread keeps reading and switches
          // on its first read once the other thread becomes eligible.
          qcnt <= (qcnt >= QMAX) ? QMAX : qcnt + 4'd1;
        end
      end
      // Flush windows run regardless of stall.
      for (int t = 0; t < 2; t++) begin
        if (except && (except_thread == 1'(t)))
          fl[t] <= 3'(FLUSH_CYC);
        else if (fl[t] != 3'd0)
          fl[t] <= fl[t] - 3'd1;
      end
    end
  end

endmodule
